// File: rtl/fsm_decoder.sv
// Receiver for the fsm Mealy encoder. It tracks the encoder state, recovers the serial bits,
// packs them into bytes and counts illegal symbols. Two hex digits show the state and the error count.

module hex (
  input  logic [3:0] x_i,
  output logic [6:0] seg_o
);
  // Active-high segments, bit order {g,f,e,d,c,b,a}.
  always_comb begin
    seg_o = 7'h00;
    unique case (x_i)
      4'h0: seg_o = 7'h3F;
      4'h1: seg_o = 7'h06;
      4'h2: seg_o = 7'h5B;
      4'h3: seg_o = 7'h4F;
      4'h4: seg_o = 7'h66;
      4'h5: seg_o = 7'h6D;
      4'h6: seg_o = 7'h7D;
      4'h7: seg_o = 7'h07;
      4'h8: seg_o = 7'h7F;
      4'h9: seg_o = 7'h6F;
      4'hA: seg_o = 7'h77;
      4'hB: seg_o = 7'h7C;
      4'hC: seg_o = 7'h39;
      4'hD: seg_o = 7'h5E;
      4'hE: seg_o = 7'h79;
      4'hF: seg_o = 7'h71;
      default: seg_o = 7'h00;
    endcase
  end
endmodule

module fsm_decoder #(
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sym_valid,
  input  logic [1:0]       sym,
  output logic             bit_valid,
  output logic             bit_out,
  output logic             byte_valid,
  output logic [7:0]       byte_out,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state,
  output logic [6:0]       o1,
  output logic [6:0]       o0
);
  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} state_e;

  state_e           state_q, state_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             byte_valid_q, byte_valid_d;
  logic [7:0]       byte_out_q, byte_out_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       shreg_q, shreg_d;

  logic             legal;
  logic             dec_bit;
  state_e           dec_next;
  logic [7:0]       shift_next;

  // Inverse of the encoder table: which input bit produced this symbol from this state.
  always_comb begin
    legal    = 1'b0;
    dec_bit  = 1'b0;
    dec_next = S0;
    unique case (state_q)
      S0: begin
        if (sym == 2'd0)      begin legal = 1'b1; dec_bit = 1'b0; dec_next = S0; end
        else if (sym == 2'd1) begin legal = 1'b1; dec_bit = 1'b1; dec_next = S1; end
      end
      S1: begin
        if (sym == 2'd0)      begin legal = 1'b1; dec_bit = 1'b0; dec_next = S2; end
        else if (sym == 2'd2) begin legal = 1'b1; dec_bit = 1'b1; dec_next = S3; end
      end
      S2: begin
        if (sym == 2'd1)      begin legal = 1'b1; dec_bit = 1'b0; dec_next = S2; end
        else if (sym == 2'd0) begin legal = 1'b1; dec_bit = 1'b1; dec_next = S3; end
      end
      S3: begin
        if (sym == 2'd1)      begin legal = 1'b1; dec_bit = 1'b0; dec_next = S1; end
        else if (sym == 2'd0) begin legal = 1'b1; dec_bit = 1'b1; dec_next = S0; end
      end
      default: ;
    endcase
  end

  assign shift_next = {shreg_q[6:0], dec_bit};

  always_comb begin
    state_d      = state_q;
    bit_out_d    = bit_out_q;
    bit_valid_d  = 1'b0;
    byte_valid_d = 1'b0;
    byte_out_d   = byte_out_q;
    err_d        = 1'b0;
    err_cnt_d    = err_cnt_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    if (sym_valid) begin
      if (legal) begin
        state_d     = dec_next;
        bit_out_d   = dec_bit;
        bit_valid_d = 1'b1;
        shreg_d     = shift_next;
        cnt_d       = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          byte_out_d   = shift_next;
          byte_valid_d = 1'b1;
        end
      end else begin
        // Resync: drop the partial byte and restart from the encoder's reset state.
        state_d = S0;
        err_d   = 1'b1;
        shreg_d = 8'h00;
        cnt_d   = 3'd0;
        if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_out_q   <= 8'h00;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
      cnt_q        <= 3'd0;
      shreg_q      <= 8'h00;
    end else begin
      state_q      <= state_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      byte_valid_q <= byte_valid_d;
      byte_out_q   <= byte_out_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
    end
  end

  assign state      = state_q;
  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign byte_valid = byte_valid_q;
  assign byte_out   = byte_out_q;
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;

  logic [3:0] err_nib;
  generate
    if (ERR_W >= 4) begin : g_nib_wide
      assign err_nib = err_cnt_q[3:0];
    end else begin : g_nib_narrow
      assign err_nib = {{(4 - ERR_W){1'b0}}, err_cnt_q};
    end
  endgenerate

  hex u_hex_state (.x_i({2'b00, state_q}), .seg_o(o1));
  hex u_hex_err   (.x_i(err_nib),          .seg_o(o0));
endmodule

// File: tb/tb_fsm_decoder.sv
// Bench for fsm_decoder: directed sequences with literal expectations, then random traffic
// compared every cycle against a table-driven model of the encoder.

module tb_fsm_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sym_valid = 1'b0;
  logic [1:0] sym = 2'd0;
  logic       bit_valid, bit_out, byte_valid, err;
  logic [7:0] byte_out;
  logic [3:0] err_cnt;
  logic [1:0] state;
  logic [6:0] o1, o0;

  always #5 clk = ~clk;

  fsm_decoder #(.ERR_W(4)) dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym(sym),
    .bit_valid(bit_valid), .bit_out(bit_out), .byte_valid(byte_valid),
    .byte_out(byte_out), .err(err), .err_cnt(err_cnt), .state(state),
    .o1(o1), .o0(o0)
  );

  // Encoder: [state][input bit] -> symbol / next state.
  int enc_sym [4][2] = '{'{0, 1}, '{0, 2}, '{1, 0}, '{1, 0}};
  int enc_nxt [4][2] = '{'{0, 1}, '{2, 3}, '{2, 3}, '{1, 0}};
  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int checks = 0;
  int errors = 0;
  int n_bv = 0, n_byv = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Which input bit would have made the encoder emit s from state st; -1 if none.
  function automatic int decode(input int st, input int s);
    for (int b = 0; b < 2; b++)
      if (enc_sym[st][b] == s) return b;
    return -1;
  endfunction

  int m_state = 0, m_bit = 0, m_bv = 0, m_byte = 0, m_byv = 0, m_err = 0, m_errcnt = 0;
  int m_nbits = 0, m_acc = 0;
  bit chk_en = 1'b0;
  int cur_dec;
  always_comb cur_dec = decode(m_state, int'(sym));

  always @(posedge clk) begin
    m_bv  <= 0;
    m_byv <= 0;
    m_err <= 0;
    if (rst) begin
      m_state <= 0; m_bit <= 0; m_byte <= 0; m_errcnt <= 0;
      m_nbits <= 0; m_acc <= 0; chk_en <= 1'b1;
    end else if (sym_valid) begin
      if (cur_dec >= 0) begin
        m_state <= enc_nxt[m_state][cur_dec];
        m_bit   <= cur_dec;
        m_bv    <= 1;
        m_acc   <= ((m_acc * 2) + cur_dec) % 256;
        m_nbits <= (m_nbits + 1) % 8;
        if (m_nbits == 7) begin
          m_byte <= ((m_acc * 2) + cur_dec) % 256;
          m_byv  <= 1;
        end
      end else begin
        m_state  <= 0;
        m_err    <= 1;
        m_acc    <= 0;
        m_nbits  <= 0;
        m_errcnt <= (m_errcnt < 15) ? m_errcnt + 1 : 15;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", 32'(state), 32'(m_state));
      chk("bit_out", 32'(bit_out), 32'(m_bit));
      chk("bit_valid", 32'(bit_valid), 32'(m_bv));
      chk("byte_out", 32'(byte_out), 32'(m_byte));
      chk("byte_valid", 32'(byte_valid), 32'(m_byv));
      chk("err", 32'(err), 32'(m_err));
      chk("err_cnt", 32'(err_cnt), 32'(m_errcnt));
      chk("o1", 32'(o1), 32'(seg_tbl[m_state % 4]));
      chk("o0", 32'(o0), 32'(seg_tbl[m_errcnt % 16]));
      if (bit_valid === 1'b1) n_bv <= n_bv + 1;
      if (byte_valid === 1'b1) n_byv <= n_byv + 1;
      if (err === 1'b1) n_err <= n_err + 1;
    end
  end

  // Drive for one cycle starting at posedge+1; returns at the next posedge+1.
  task automatic cyc(input logic v, input logic [1:0] s, input logic r);
    sym_valid = v; sym = s; rst = r;
    @(posedge clk); #1;
  endtask

  int b2_seq [8] = '{1, 0, 0, 0, 0, 0, 1, 0};
  int exp_bits [4] = '{1, 1, 0, 1};
  int t1_syms [4] = '{1, 2, 1, 2};
  int base_bv, base_byv, base_err;

  initial begin
    @(posedge clk); #1;
    cyc(1'b0, 2'd0, 1'b1);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_byte_out", 32'(byte_out), 32'h00);
    chk("reset_err_cnt", 32'(err_cnt), 32'd0);

    // 1,2,1,2 -> bits 1,1,0,1, ends in S3
    base_bv = n_bv;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 2'(t1_syms[i]), 1'b0);
      chk("t1_bit_out", 32'(bit_out), 32'(exp_bits[i]));
      chk("t1_bit_valid", 32'(bit_valid), 32'd1);
    end
    chk("t1_state", 32'(state), 32'd3);
    chk("t1_err", 32'(err), 32'd0);
    cyc(1'b0, 2'd0, 1'b0);
    chk("t1_bv_count", 32'(n_bv - base_bv), 32'd4);

    // 0xB2 byte
    cyc(1'b0, 2'd0, 1'b1);
    base_byv = n_byv;
    for (int i = 0; i < 8; i++) cyc(1'b1, 2'(b2_seq[i]), 1'b0);
    chk("t2_byte_valid", 32'(byte_valid), 32'd1);
    chk("t2_byte_out", 32'(byte_out), 32'hB2);
    chk("t2_state", 32'(state), 32'd2);
    cyc(1'b0, 2'd0, 1'b0);
    chk("t2_byv_count", 32'(n_byv - base_byv), 32'd1);

    // Illegal symbol then resync
    cyc(1'b0, 2'd0, 1'b1);
    cyc(1'b1, 2'd2, 1'b0);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_err_cnt", 32'(err_cnt), 32'd1);
    chk("t3_state", 32'(state), 32'd0);
    chk("t3_bit_valid", 32'(bit_valid), 32'd0);
    chk("t3_o0", 32'(o0), 32'h06);
    cyc(1'b1, 2'd1, 1'b0);
    chk("t3_err_gone", 32'(err), 32'd0);
    chk("t3_bit_a", 32'(bit_out), 32'd1);
    cyc(1'b1, 2'd2, 1'b0);
    chk("t3_bit_b", 32'(bit_out), 32'd1);

    // Partial byte discarded by an illegal symbol
    cyc(1'b0, 2'd0, 1'b1);
    base_byv = n_byv;
    cyc(1'b1, 2'd1, 1'b0); cyc(1'b1, 2'd0, 1'b0); cyc(1'b1, 2'd0, 1'b0);
    cyc(1'b1, 2'd2, 1'b0);
    chk("t4_err", 32'(err), 32'd1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 2'(b2_seq[i]), 1'b0);
    chk("t4_byte_out", 32'(byte_out), 32'hB2);
    cyc(1'b0, 2'd0, 1'b0);
    chk("t4_byv_count", 32'(n_byv - base_byv), 32'd1);

    // Saturation
    cyc(1'b0, 2'd0, 1'b1);
    base_err = n_err;
    for (int i = 0; i < 17; i++) cyc(1'b1, 2'd3, 1'b0);
    chk("t5_err_cnt", 32'(err_cnt), 32'd15);
    chk("t5_o0", 32'(o0), 32'h71);
    cyc(1'b0, 2'd0, 1'b0);
    chk("t5_err_pulses", 32'(n_err - base_err), 32'd17);

    // Gapped 0xB2, then mid-byte reset
    cyc(1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      int gaps;
      gaps = int'($urandom_range(0, 3));
      for (int g = 0; g < gaps; g++) cyc(1'b0, 2'($urandom_range(0, 3)), 1'b0);
      cyc(1'b1, 2'(b2_seq[i]), 1'b0);
    end
    chk("t6_byte_out", 32'(byte_out), 32'hB2);
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'(b2_seq[i]), 1'b0);
    cyc(1'b0, 2'd0, 1'b1);
    chk("t6_rst_state", 32'(state), 32'd0);
    chk("t6_rst_bit_out", 32'(bit_out), 32'd0);
    chk("t6_rst_byte_out", 32'(byte_out), 32'h00);
    chk("t6_rst_err_cnt", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 2'(b2_seq[i]), 1'b0);
    chk("t6_byte_after_rst", 32'(byte_out), 32'hB2);

    // Reset wins over a simultaneous symbol
    cyc(1'b1, 2'd1, 1'b1);
    chk("t7_state", 32'(state), 32'd0);
    chk("t7_bit_valid", 32'(bit_valid), 32'd0);

    // Random traffic, mostly legal symbols
    for (int i = 0; i < 4000; i++) begin
      logic       r, v;
      logic [1:0] s;
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < 85) s = 2'(enc_sym[m_state % 4][$urandom_range(0, 1)]);
      else s = 2'($urandom_range(0, 3));
      cyc(v, s, r);
    end
    cyc(1'b0, 2'd0, 1'b0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fsm_decoder.md
# fsm_decoder

Receiving end of the serial-to-symbol link driven by the `fsm` Mealy encoder. It consumes the encoder's 2-bit output symbol stream, runs its own copy of the encoder state, and recovers the original serial input bit. It assembles the recovered bits into bytes, flags illegal symbols, and counts errors. It drives two 7-segment digits through the existing `hex` module: current state and error count.

## Interface
- `ERR_W`, default 4: width of the saturating error counter.
- `clk`, input, 1: system clock; all logic on posedge.
- `rst`, input, 1: synchronous, active-high reset.
- `sym_valid`, input, 1: `sym` carries a new symbol this cycle.
- `sym`, input, 2: encoder output symbol.
- `bit_valid`, output, 1: one-cycle pulse; `bit_out` is a newly decoded bit.
- `bit_out`, output, 1: decoded bit; holds its value between pulses.
- `byte_valid`, output, 1: one-cycle pulse when 8 bits have been assembled.
- `byte_out`, output, 8: assembled byte; first decoded bit lands in bit 7; holds between pulses.
- `err`, output, 1: one-cycle pulse on an illegal symbol.
- `err_cnt`, output, ERR_W: saturating count of illegal symbols.
- `state`, output, 2: current tracked encoder state.
- `o1`, output, 7: `hex` digit showing `state`.
- `o0`, output, 7: `hex` digit showing `err_cnt[3:0]`.

## Operation
- Tracked encoder behaviour, listed as state: in=0 → (sym, next) / in=1 → (sym, next):
  - S0: 0,S0 / 1,S1
  - S1: 0,S2 / 2,S3
  - S2: 1,S2 / 0,S3
  - S3: 1,S1 / 0,S0
- Decode runs only in cycles where `sym_valid`=1. Decoding depends on the current `state`:
  - S0: sym 0 → bit 0, stay S0; sym 1 → bit 1, go S1; sym 2 or 3 → illegal.
  - S1: sym 0 → bit 0, go S2; sym 2 → bit 1, go S3; sym 1 or 3 → illegal.
  - S2: sym 1 → bit 0, stay S2; sym 0 → bit 1, go S3; sym 2 or 3 → illegal.
  - S3: sym 1 → bit 0, go S1; sym 0 → bit 1, go S0; sym 2 or 3 → illegal.
- On a legal symbol:
  - Update `bit_out` and pulse `bit_valid`.
  - Shift the bit into an 8-bit shift register (shift left, new bit at LSB) and increment a 3-bit bit counter.
  - When the counter wraps 7→0, load `byte_out` with the completed shift value (including the current bit) and pulse `byte_valid` in the same cycle as `bit_valid`.
- On an illegal symbol:
  - Pulse `err`.
  - Force `state` to S0 (resync).
  - Clear the shift register and bit counter; the partial byte is discarded.
  - Increment `err_cnt`, saturating at 2^ERR_W−1.
  - No `bit_valid` pulse; `bit_out` and `byte_out` are unchanged.
- When `sym_valid`=0, all state holds and all pulses are 0.
- `o1` and `o0` are combinational `hex` decodes of registered values.

## Timing
- All outputs except `o1`/`o0` are registered. Results appear the cycle after the `sym_valid` sample (latency 1).
- A symbol is accepted every cycle `sym_valid`=1; there is no backpressure and no ready signal.
- Reset values: `state`=S0; `bit_out`=0; `bit_valid`=0; `byte_valid`=0; `byte_out`=0x00; `err`=0; `err_cnt`=0; bit counter=0; shift register=0.
- `rst` high in the same cycle as `sym_valid`: reset wins and the symbol is dropped.
- Reset mid-byte discards the partial byte.
- `err_cnt` at saturation: `err` still pulses, the count stays at its maximum.

## Test plan
- Reset, then symbols 1,2,1,2 on consecutive cycles → `bit_out` 1,1,0,1 with four `bit_valid` pulses; final `state`=S3; `err`=0.
- From S0, symbols 1,0,0,0,0,0,1,0 → `byte_valid` pulses once, with the 8th `bit_valid`; `byte_out`=0xB2; final `state`=S2.
- From S0, symbol 2 → `err` pulses for one cycle; `err_cnt`=1; `state`=S0; no `bit_valid`. Then symbols 1,2 decode as 1,1.
- Send 3 legal symbols, then an illegal one, then 8 legal symbols → exactly one `byte_valid`, and `byte_out` holds only the last 8 bits.
- 17 illegal symbols → `err_cnt` saturates at 15, and `err` pulses 17 times.
- Insert random `sym_valid`=0 gaps into the 0xB2 sequence → identical `byte_out`. Assert `rst` after 4 bits → all outputs return to reset values; a full 8-symbol sequence afterwards yields a correct byte.
